// File: rtl/display_pkg.sv
// Shared types for the seven-segment display path.
package display_pkg;
  typedef logic [3:0] digit_t;
  typedef enum logic {EMPTY, FULL} pend_state_t;
  localparam int DEFAULT_NDIGITS = 4;
endpackage

// File: rtl/digit_scanner_tick_gen.sv
// Prescaler: free-running count 0..PRESCALE-1, tick high on the last count.
module tick_gen #(
  parameter int PRESCALE = 50000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= '0;
    end else if (pc == PW'(PRESCALE - 1)) begin
      pc <= '0;
    end else begin
      pc <= pc + PW'(1);
    end
  end

  assign tick = (pc == PW'(PRESCALE - 1));
endmodule

// File: rtl/digit_scanner.sv
// Multiplexed scan driver for a common-anode seven-segment display.
// Optional leading-zero blanking: define DIGIT_SCANNER_LZB_EN.
module digit_scanner
  import display_pkg::*;
#(
  parameter int NDIGITS  = DEFAULT_NDIGITS,
  parameter int PRESCALE = 50000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4*NDIGITS-1:0]   value_in,
  input  logic                   load_valid,
  output logic                   load_ready,
  output digit_t                 digit,
  output logic [NDIGITS-1:0]     an,
  output logic                   frame_tick
);
  localparam int SW = $clog2(NDIGITS);
  localparam int W  = 4 * NDIGITS;

  logic [SW-1:0] slot;
  logic [W-1:0]  disp;
  logic [W-1:0]  pend;
  pend_state_t   state;
  logic          tick;
  logic          boundary;

  tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  assign boundary = tick && (slot == SW'(NDIGITS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      slot       <= '0;
      disp       <= '0;
      pend       <= '0;
      state      <= EMPTY;
      load_ready <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= boundary;
      if (tick) begin
        slot <= boundary ? '0 : slot + SW'(1);
      end
      // A load accepted on a boundary edge lands in pend only; it commits
      // at the following boundary.
      case (state)
        EMPTY: begin
          if (load_valid) begin
            pend       <= value_in;
            state      <= FULL;
            load_ready <= 1'b0;
          end
        end
        FULL: begin
          if (boundary) begin
            disp       <= pend;
            state      <= EMPTY;
            load_ready <= 1'b1;
          end
        end
        default: begin
          state      <= EMPTY;
          load_ready <= 1'b1;
        end
      endcase
    end
  end

  assign digit = disp[4*slot +: 4];

`ifdef DIGIT_SCANNER_LZB_EN
  // zrun[k]: nibbles k..NDIGITS-1 are all zero; slot 0 is forced lit.
  logic [NDIGITS:0] zrun;
  logic             blank;

  assign zrun[NDIGITS] = 1'b1;
  assign zrun[0]       = 1'b0;
  for (genvar k = 1; k < NDIGITS; k++) begin : g_lzb
    assign zrun[k] = zrun[k+1] & (disp[4*k +: 4] == 4'h0);
  end

  assign blank = zrun[slot];
  assign an    = blank ? '1 : ~(NDIGITS'(1) << slot);
`else
  assign an = ~(NDIGITS'(1) << slot);
`endif
endmodule

// File: tb/tb_digit_scanner.sv
// Self-checking bench for digit_scanner (NDIGITS=4, PRESCALE=4) against a
// cycle-count based reference model.
module tb_digit_scanner;
  localparam int N = 4;
  localparam int P = 4;
  localparam int F = N * P;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value_in = '0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [3:0]  digit;
  logic [3:0]  an;
  logic        frame_tick;

  int checks = 0;
  int failures = 0;

  // Reference model: t counts cycles since reset release.
  int          t = 0;
  logic [15:0] m_disp = '0;
  logic [15:0] m_pend = '0;
  bit          m_full = 1'b0;

  always #5 clk = ~clk;

  digit_scanner #(.NDIGITS(N), .PRESCALE(P)) dut (
    .clk       (clk),
    .reset     (reset),
    .value_in  (value_in),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .digit     (digit),
    .an        (an),
    .frame_tick(frame_tick)
  );

  task automatic step();
    @(posedge clk);
    if (reset) begin
      t = 0; m_disp = '0; m_pend = '0; m_full = 1'b0;
    end else begin
      t = t + 1;
      if (m_full && (t % F == 0)) begin
        m_disp = m_pend; m_full = 1'b0;
      end else if (!m_full && load_valid) begin
        m_pend = value_in; m_full = 1'b1;
      end
    end
    #1;
  endtask

  function automatic logic [9:0] expected();
    int s = (t / P) % N;
    logic [3:0] d = m_disp[4*s +: 4];
    logic [3:0] a = ~(4'b0001 << s);
`ifdef DIGIT_SCANNER_LZB_EN
    if (s > 0 && (m_disp >> (4*s)) == 16'h0) a = 4'hF;
`endif
    return {d, a, ~m_full, (t != 0) && (t % F == 0)};
  endfunction

  task automatic do_reset(input int n);
    reset = 1'b1; load_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(3);
    checks++;
    if ({digit, an, load_ready, frame_tick} !== {4'h0, 4'b1110, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h", {digit, an, load_ready, frame_tick},
               {4'h0, 4'b1110, 1'b1, 1'b0});
    end
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if ({digit, an, load_ready, frame_tick} !== expected()) begin
        failures++;
        $display("FAIL reset_scan t=%0d got=%h exp=%h", t,
                 {digit, an, load_ready, frame_tick}, expected());
      end
      if (t == 4) begin
        checks++;
        if (an !== 4'b1101) begin
          failures++; $display("FAIL first_slot_step an=%b exp=1101", an);
        end
      end
      if (t == 15 || t == 16) begin
        checks++;
        if (frame_tick !== (t == 16)) begin
          failures++; $display("FAIL first_frame_tick t=%0d got=%b exp=%b", t, frame_tick, t == 16);
        end
      end
    end
  endtask

  task automatic test_load_commit();
    logic [3:0] seq_d [4] = '{4'hF, 4'h2, 4'hA, 4'h1};
    logic [3:0] seq_a [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    do_reset(1);
    step(); step();
    value_in = 16'h1A2F; load_valid = 1'b1;
    step();
    load_valid = 1'b0; value_in = 16'(($urandom));
    checks++;
    if (load_ready !== 1'b0) begin
      failures++; $display("FAIL load_ready_drop got=%b exp=0", load_ready);
    end
    for (int i = 0; i < 2*F; i++) begin
      step();
      checks++;
      if ({digit, an, load_ready, frame_tick} !== expected()) begin
        failures++;
        $display("FAIL load_commit t=%0d got=%h exp=%h", t,
                 {digit, an, load_ready, frame_tick}, expected());
      end
      if (t >= F && t < 2*F && (t % P == 0)) begin
        checks++;
        if (digit !== seq_d[(t-F)/P] || an !== seq_a[(t-F)/P] || load_ready !== 1'b1) begin
          failures++;
          $display("FAIL commit_sequence t=%0d digit=%h an=%b rdy=%b exp digit=%h an=%b rdy=1",
                   t, digit, an, load_ready, seq_d[(t-F)/P], seq_a[(t-F)/P]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    value_in = 16'h1234; load_valid = 1'b1;
    step();
    value_in = 16'h5678;
    for (int i = 0; i < 3*F; i++) begin
      step();
      checks++;
      if ({digit, an, load_ready, frame_tick} !== expected()) begin
        failures++;
        $display("FAIL back_to_back t=%0d got=%h exp=%h", t,
                 {digit, an, load_ready, frame_tick}, expected());
      end
    end
    load_valid = 1'b0;
  endtask

  task automatic test_boundary_collision();
    int guard = 0;
    load_valid = 1'b0;
    while ((m_full || (t % F) != F - 1) && guard < 4*F) begin
      step(); guard++;
    end
    checks++;
    if (guard >= 4*F) begin
      failures++; $display("FAIL collision_setup timeout got=%0d exp<%0d", guard, 4*F);
    end
    value_in = 16'hBEEF; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 2*F + 2; i++) begin
      checks++;
      if ({digit, an, load_ready, frame_tick} !== expected()) begin
        failures++;
        $display("FAIL boundary_collision t=%0d got=%h exp=%h", t,
                 {digit, an, load_ready, frame_tick}, expected());
      end
      step();
    end
  endtask

  task automatic test_reset_midframe();
    int guard = 0;
    value_in = 16'(($urandom)); load_valid = 1'b1;
    while (!(m_full && ((t / P) % N) == 2) && guard < 4*F) begin
      step(); guard++;
      load_valid = !m_full;
    end
    load_valid = 1'b0;
    checks++;
    if (guard >= 4*F) begin
      failures++; $display("FAIL midframe_setup timeout got=%0d exp<%0d", guard, 4*F);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({digit, an, load_ready, frame_tick} !== {4'h0, 4'b1110, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset_midframe got=%h exp=%h", {digit, an, load_ready, frame_tick},
               {4'h0, 4'b1110, 1'b1, 1'b0});
    end
    for (int i = 0; i < F + 2; i++) begin
      step();
      checks++;
      if ({digit, an, load_ready, frame_tick} !== expected()) begin
        failures++;
        $display("FAIL after_midframe_reset t=%0d got=%h exp=%h", t,
                 {digit, an, load_ready, frame_tick}, expected());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      load_valid = ($urandom_range(3) == 0);
      value_in   = 16'(($urandom));
      reset      = ($urandom_range(249) == 0);
      step();
      reset = 1'b0;
      checks++;
      if ({digit, an, load_ready, frame_tick} !== expected()) begin
        failures++;
        $display("FAIL random t=%0d got=%h exp=%h", t,
                 {digit, an, load_ready, frame_tick}, expected());
      end
    end
    load_valid = 1'b0;
  endtask

  task automatic test_blanking();
    logic [15:0] vals [2] = '{16'h0007, 16'h0000};
    for (int v = 0; v < 2; v++) begin
      int guard = 0;
      while (m_full && guard < 2*F) begin step(); guard++; end
      value_in = vals[v]; load_valid = 1'b1;
      step();
      load_valid = 1'b0;
      guard = 0;
      while (m_full && guard < 2*F) begin step(); guard++; end
      checks++;
      if (guard >= 2*F || m_disp !== vals[v]) begin
        failures++; $display("FAIL blank_commit timeout got=%0d exp<%0d", guard, 2*F);
      end
      for (int i = 0; i < F; i++) begin
        checks++;
        if ({digit, an, load_ready, frame_tick} !== expected()) begin
          failures++;
          $display("FAIL blanking val=%h t=%0d got=%h exp=%h", vals[v], t,
                   {digit, an, load_ready, frame_tick}, expected());
        end
        step();
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_commit();
    test_back_to_back();
    test_boundary_collision();
    test_reset_midframe();
    test_random();
    test_blanking();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/digit_scanner.md
# digit_scanner

Time-multiplexed scan driver for an `NDIGITS`-digit common-anode seven-segment display. It sits directly upstream of `sevenseg`. It holds a packed hex value and steps through one digit slot per prescaler period. Each slot presents the 4-bit nibble on `digit`, which feeds the `sevenseg` input, and drives the matching active-low anode. New values arrive over a valid/ready handshake and take effect only at a frame boundary, so the display never tears.

## Interface
- `NDIGITS`, default 4: number of digit slots; legal range 2..8.
- `PRESCALE`, default 50000: clock cycles per slot; must be >= 2.

- `clk`  in  1  system clock; the block's only clock.
- `reset`  in  1  synchronous, active-high reset.
- `value_in`  in  4*NDIGITS  packed value; nibble k belongs to slot k, and slot 0 is the least significant digit.
- `load_valid`  in  1  `value_in` is offered.
- `load_ready`  out  1  pending buffer is empty, so an offer can be accepted.
- `digit`  out  4  nibble of the active slot; connects to `sevenseg` `digit`.
- `an`  out  NDIGITS  active-low anode enables; at most one bit is low.
- `frame_tick`  out  1  one-cycle pulse in the first cycle of each frame.

## Operation
- State held in registers:
  - prescaler count `pc`, range 0..PRESCALE-1
  - slot index `slot`, range 0..NDIGITS-1
  - display register `disp`
  - pending register `pend`
  - pending FSM with states EMPTY and FULL
- Slot stepping:
  - `pc` increments every cycle.
  - When `pc == PRESCALE-1`, `pc` wraps to 0 and `slot` advances by one.
  - After NDIGITS-1, `slot` wraps to 0. This wrap is the frame boundary.
- Outputs are decoded from registers only; there is no combinational path from inputs to outputs.
  - `digit = disp[4*slot +: 4]`
  - `an = ~(1 << slot)`, unless the slot is blanked (see Configuration).
- Pending FSM:
  - In EMPTY, `load_ready` = 1. A clock edge with `load_valid` high captures `value_in` into `pend` and moves the FSM to FULL.
  - In FULL, `load_ready` = 0 and `load_valid` is ignored.
  - At the frame-boundary edge in FULL: `disp <= pend` and the FSM returns to EMPTY.
- Simultaneous events:
  - A load accepted in EMPTY on the same edge as a frame boundary goes into `pend` only. It commits at the next boundary, one full frame later.
  - A commit and a new acceptance never occur on the same edge, because `load_ready` is 0 in FULL.
- Reset values:
  - `pc` = 0, `slot` = 0, `disp` = 0, `pend` = 0, FSM = EMPTY.
  - Outputs: `load_ready` = 1, `digit` = 0, `an` = all ones except bit 0 = 0, `frame_tick` = 0.
- Reset asserted mid-frame or while FULL:
  - The pending value is discarded and `disp` is cleared.
  - Scanning restarts at slot 0 on the cycle after reset deasserts.

## Timing
- Slot period: exactly PRESCALE cycles. Frame period: NDIGITS*PRESCALE cycles.
- `frame_tick` is a register set at the boundary edge. It is high for exactly the first cycle in which `slot` = 0 of each new frame.
- `frame_tick` does not fire for the slot-0 period that follows reset. The first pulse comes NDIGITS*PRESCALE cycles after reset deasserts.
- Load latency: acceptance occurs at the edge where `load_valid && load_ready`. The value appears on `digit` at the next frame boundary, between 1 and NDIGITS*PRESCALE cycles later.
- `load_ready` rises in the cycle after the commit edge.

## Configuration
- `DIGIT_SCANNER_LZB_EN`, leading-zero blanking.
  - Defined: for any slot k > 0 where every nibble of `disp` from slot k up to slot NDIGITS-1 is zero, `an` is all ones for that slot period. `digit` still presents the nibble. Slot 0 is never blanked.
  - Undefined: every slot is lit in turn and zeros display as "0".
- The macro does not change slot timing or `frame_tick` in either case.

## Structure
- Package `display_pkg`:
  - `typedef logic [3:0] digit_t`
  - `typedef enum {EMPTY, FULL} pend_state_t`
  - `localparam DEFAULT_NDIGITS = 4`
- Sub-module `tick_gen`:
  - Parameter `PRESCALE`; ports `clk`, `reset`, `tick`.
  - `tick` is high in the cycle where `pc == PRESCALE-1`.
  - `digit_scanner` instantiates it once.
- The top level instantiates `digit_scanner` beside `sevenseg` and connects `digit` straight to it.

## Test plan
All scenarios use NDIGITS=4 and PRESCALE=4.
- Reset release:
  - Stimulus: hold `reset` for 3 cycles, then release.
  - Response: `an` = 1110, `digit` = 0, `load_ready` = 1.
  - `slot` advances after 4 cycles and `an` = 1101. The first `frame_tick` comes 16 cycles after release.
- Load and commit:
  - Stimulus: offer `value_in` = 16'h1A2F at cycle 2.
  - Response: `load_ready` = 0 at cycle 3.
  - At the next boundary, `digit` sequences F, 2, A, 1 with `an` = 1110, 1101, 1011, 0111. `load_ready` = 1 after the commit.
- Back-pressure:
  - Stimulus: hold `load_valid` high with 16'h1234, then 16'h5678 while FULL.
  - Response: only 16'h1234 is committed. 16'h5678 is accepted at the first edge after `load_ready` returns to 1 and commits one frame later.
- Boundary collision:
  - Stimulus: accept 16'hBEEF on the boundary edge.
  - Response: the old `disp` is shown for the entire next frame. 16'hBEEF appears at the following boundary.
- Reset mid-frame:
  - Stimulus: assert `reset` while FULL in slot 2.
  - Response: `disp` = 0, `pend` is discarded, `an` = 1110, `load_ready` = 1.
- Blanking with `DIGIT_SCANNER_LZB_EN` defined:
  - Stimulus: commit 16'h0007.
  - Response: slot 0 has `an` = 1110. Slots 1–3 have `an` = 1111.
  - With 16'h0000, only slot 0 is lit. Without the macro, all four slots light.
